sgmii_link_seq: RTL and testbench

//  Bring-up and supervision sequencer for the SGMII PCS/PMA core and the GMII MAC behind it.

---
 rtl/sgmii_link_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_sgmii_link_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sgmii_link_seq.sv
// rtl/sgmii_link_seq.sv - SGMII PCS/PMA bring-up and link supervision sequencer
module sgmii_link_seq #(
  parameter int RST_CYCLES   = 16,
  parameter int DONE_TIMEOUT = 1024,
  parameter int LINK_TIMEOUT = 4096,
  parameter int DEBOUNCE     = 8,
  parameter int MAX_RETRY    = 7
) (
  input  logic        sys0_clk,
  input  logic        sys0_rst,
  input  logic        restart,
  input  logic [1:0]  cfg_speed,
  input  logic        cfg_an_en,
  input  logic        resetdone,
  input  logic [15:0] status_vector,
  output logic        pma_reset,
  output logic        pcs_reset,
  output logic        gmii_rstn,
  output logic [4:0]  configuration_vector,
  output logic        speed_is_10_100,
  output logic        speed_is_100,
  output logic        link_up,
  output logic        link_drop,
  output logic [2:0]  retry_count,
  output logic        fail
);

  localparam int TMAX_A = (DONE_TIMEOUT > LINK_TIMEOUT) ? DONE_TIMEOUT : LINK_TIMEOUT;
  localparam int TMAX   = (TMAX_A > RST_CYCLES) ? TMAX_A : RST_CYCLES;
  localparam int CW     = $clog2(TMAX) + 1;
  localparam int DW     = $clog2(DEBOUNCE) + 1;

  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] DONE_LAST = CW'(DONE_TIMEOUT - 1);
  localparam logic [CW-1:0] LINK_LAST = CW'(LINK_TIMEOUT - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE - 1);
  localparam logic [2:0]    RETRY_LIM = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    RESET_HOLD,
    WAIT_DONE,
    WAIT_LINK,
    LINK_UP,
    FAIL_ST
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [2:0]    retry_q, retry_d;
  logic          pma_q, pma_d;
  logic          gmii_q, gmii_d;
  logic [4:0]    cfg_q, cfg_d;
  logic          s10_100_q, s10_100_d;
  logic          s100_q, s100_d;
  logic          link_up_q, link_up_d;
  logic          drop_q, drop_d;
  logic          fail_q, fail_d;

  logic          link_lvl;
  logic          cfg_s10_100;
  logic          cfg_s100;
  logic          enter;
  logic          tmo;
  logic          hold_like;
  logic          unused_status;

  assign link_lvl      = status_vector[0];
  assign unused_status = ^status_vector[15:1];

  // 11 decodes to 1G so it never counts as a change against a latched 1G
  assign cfg_s10_100 = (cfg_speed == 2'b01) || (cfg_speed == 2'b10);
  assign cfg_s100    = (cfg_speed == 2'b01);

  // Next-state, counters and registered-output values; later events override earlier ones
  always_comb begin
    state_d   = state_q;
    enter     = 1'b0;
    tmo       = 1'b0;
    retry_d   = retry_q;
    drop_d    = 1'b0;
    deb_d     = deb_q;
    s10_100_d = s10_100_q;
    s100_d    = s100_q;
    cfg_d     = cfg_q;

    case (state_q)
      RESET_HOLD: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_DONE;
          enter   = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (cnt_q == DONE_LAST) begin
          tmo = 1'b1;
        end else if (resetdone) begin
          state_d = WAIT_LINK;
          enter   = 1'b1;
        end
      end
      WAIT_LINK: begin
        if (!resetdone) begin
          state_d = RESET_HOLD;
          enter   = 1'b1;
        end else if (cnt_q == LINK_LAST) begin
          tmo = 1'b1;
        end else if (link_lvl) begin
          if (deb_q == DEB_LAST) begin
            state_d = LINK_UP;
            enter   = 1'b1;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end else begin
          deb_d = '0;
        end
      end
      LINK_UP: begin
        if (!resetdone) begin
          state_d = RESET_HOLD;
          enter   = 1'b1;
        end else if ({cfg_s10_100, cfg_s100} != {s10_100_q, s100_q}) begin
          state_d = RESET_HOLD;
          enter   = 1'b1;
        end else if (!link_lvl) begin
          if (deb_q == DEB_LAST) begin
            state_d = RESET_HOLD;
            enter   = 1'b1;
            drop_d  = 1'b1;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end else begin
          deb_d = '0;
        end
      end
      FAIL_ST: begin
        state_d = FAIL_ST;
      end
      default: begin
        state_d = RESET_HOLD;
        enter   = 1'b1;
      end
    endcase

    if (tmo) begin
      retry_d = (retry_q == 3'd7) ? retry_q : retry_q + 3'd1;
      state_d = (retry_q == RETRY_LIM) ? FAIL_ST : RESET_HOLD;
      enter   = 1'b1;
    end

    if (restart) begin
      state_d = RESET_HOLD;
      retry_d = 3'd0;
      enter   = 1'b1;
      drop_d  = 1'b0;
    end

    cnt_d = enter ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1);
    if (enter) begin
      deb_d = '0;
    end

    // Speed selects follow cfg_speed as seen in the first RESET_HOLD cycle
    if ((state_q == RESET_HOLD) && (cnt_q == '0)) begin
      s10_100_d = cfg_s10_100;
      s100_d    = cfg_s100;
    end

    hold_like = (state_d == RESET_HOLD) || (state_d == FAIL_ST);
    pma_d     = hold_like;
    gmii_d    = (state_d == LINK_UP);
    link_up_d = (state_d == LINK_UP);
    fail_d    = (state_d == FAIL_ST);
    if (hold_like) begin
      cfg_d = {cfg_an_en, 4'b0000};
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge sys0_clk) begin
    if (sys0_rst) begin
      state_q   <= RESET_HOLD;
      cnt_q     <= '0;
      deb_q     <= '0;
      retry_q   <= 3'd0;
      pma_q     <= 1'b1;
      gmii_q    <= 1'b0;
      cfg_q     <= 5'b00100;
      s10_100_q <= 1'b0;
      s100_q    <= 1'b0;
      link_up_q <= 1'b0;
      drop_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      deb_q     <= deb_d;
      retry_q   <= retry_d;
      pma_q     <= pma_d;
      gmii_q    <= gmii_d;
      cfg_q     <= cfg_d;
      s10_100_q <= s10_100_d;
      s100_q    <= s100_d;
      link_up_q <= link_up_d;
      drop_q    <= drop_d;
      fail_q    <= fail_d;
    end
  end

  assign pma_reset            = pma_q;
  assign pcs_reset            = pma_q;
  assign gmii_rstn            = gmii_q;
  assign configuration_vector = cfg_q;
  assign speed_is_10_100      = s10_100_q;
  assign speed_is_100         = s100_q;
  assign link_up              = link_up_q;
  assign link_drop            = drop_q;
  assign retry_count          = retry_q;
  assign fail                 = fail_q;

endmodule

// File: tb/tb_sgmii_link_seq.sv
// tb/tb_sgmii_link_seq.sv - directed table and sequence bench for sgmii_link_seq
module tb_sgmii_link_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        restart;
  logic [1:0]  cfg_speed;
  logic        cfg_an_en;
  logic        resetdone;
  logic [15:0] status_vector;
  logic        pma_reset;
  logic        pcs_reset;
  logic        gmii_rstn;
  logic [4:0]  configuration_vector;
  logic        speed_is_10_100;
  logic        speed_is_100;
  logic        link_up;
  logic        link_drop;
  logic [2:0]  retry_count;
  logic        fail;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sgmii_link_seq dut (
    .sys0_clk             (clk),
    .sys0_rst             (rst),
    .restart              (restart),
    .cfg_speed            (cfg_speed),
    .cfg_an_en            (cfg_an_en),
    .resetdone            (resetdone),
    .status_vector        (status_vector),
    .pma_reset            (pma_reset),
    .pcs_reset            (pcs_reset),
    .gmii_rstn            (gmii_rstn),
    .configuration_vector (configuration_vector),
    .speed_is_10_100      (speed_is_10_100),
    .speed_is_100         (speed_is_100),
    .link_up              (link_up),
    .link_drop            (link_drop),
    .retry_count          (retry_count),
    .fail                 (fail)
  );

  // {pma, pcs, gmii, cfg[4:0], s10_100, s100, link_up, link_drop, retry[2:0], fail}
  function automatic logic [15:0] pk(input logic pma, input logic pcs, input logic gm,
                                     input logic [4:0] cfg, input logic s1, input logic s2,
                                     input logic lu, input logic ld, input logic [2:0] r,
                                     input logic f);
    return {pma, pcs, gm, cfg, s1, s2, lu, ld, r, f};
  endfunction

  function automatic logic [15:0] outs();
    return pk(pma_reset, pcs_reset, gmii_rstn, configuration_vector, speed_is_10_100,
              speed_is_100, link_up, link_drop, retry_count, fail);
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rd, input logic [1:0] spd);
    rst           = 1'b1;
    restart       = 1'b0;
    cfg_speed     = spd;
    cfg_an_en     = 1'b1;
    resetdone     = rd;
    status_vector = 16'h0000;
    step(2);
    rst = 1'b0;
  endtask

  typedef struct {
    int          n;
    logic        rd;
    logic        lk;
    logic [1:0]  spd;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[16];

  localparam logic [4:0] CFG_AN = 5'b10000;

  logic [15:0] rst_vals;
  logic [15:0] snap;
  logic        saw_up;

  initial begin
    rst_vals = pk(1, 1, 0, 5'b00100, 0, 0, 0, 0, 3'd0, 0);

    // Bring-up with resetdone at WAIT_DONE+5, glitch tolerance, link loss, relink, speed change
    tbl[0]  = '{1,  1'b0, 1'b1, 2'b00, pk(1, 1, 0, CFG_AN, 0, 0, 0, 0, 3'd0, 0)};
    tbl[1]  = '{14, 1'b0, 1'b1, 2'b00, pk(1, 1, 0, CFG_AN, 0, 0, 0, 0, 3'd0, 0)};
    tbl[2]  = '{1,  1'b0, 1'b1, 2'b00, pk(0, 0, 0, CFG_AN, 0, 0, 0, 0, 3'd0, 0)};
    tbl[3]  = '{5,  1'b0, 1'b1, 2'b00, pk(0, 0, 0, CFG_AN, 0, 0, 0, 0, 3'd0, 0)};
    tbl[4]  = '{1,  1'b1, 1'b1, 2'b00, pk(0, 0, 0, CFG_AN, 0, 0, 0, 0, 3'd0, 0)};
    tbl[5]  = '{7,  1'b1, 1'b1, 2'b00, pk(0, 0, 0, CFG_AN, 0, 0, 0, 0, 3'd0, 0)};
    tbl[6]  = '{1,  1'b1, 1'b1, 2'b00, pk(0, 0, 1, CFG_AN, 0, 0, 1, 0, 3'd0, 0)};
    tbl[7]  = '{7,  1'b1, 1'b0, 2'b00, pk(0, 0, 1, CFG_AN, 0, 0, 1, 0, 3'd0, 0)};
    tbl[8]  = '{1,  1'b1, 1'b1, 2'b00, pk(0, 0, 1, CFG_AN, 0, 0, 1, 0, 3'd0, 0)};
    tbl[9]  = '{7,  1'b1, 1'b0, 2'b00, pk(0, 0, 1, CFG_AN, 0, 0, 1, 0, 3'd0, 0)};
    tbl[10] = '{1,  1'b1, 1'b0, 2'b00, pk(1, 1, 0, CFG_AN, 0, 0, 0, 1, 3'd0, 0)};
    tbl[11] = '{1,  1'b1, 1'b1, 2'b00, pk(1, 1, 0, CFG_AN, 0, 0, 0, 0, 3'd0, 0)};
    tbl[12] = '{23, 1'b1, 1'b1, 2'b00, pk(0, 0, 0, CFG_AN, 0, 0, 0, 0, 3'd0, 0)};
    tbl[13] = '{1,  1'b1, 1'b1, 2'b00, pk(0, 0, 1, CFG_AN, 0, 0, 1, 0, 3'd0, 0)};
    tbl[14] = '{1,  1'b1, 1'b1, 2'b01, pk(1, 1, 0, CFG_AN, 0, 0, 0, 0, 3'd0, 0)};
    tbl[15] = '{1,  1'b1, 1'b1, 2'b01, pk(1, 1, 0, CFG_AN, 1, 1, 0, 0, 3'd0, 0)};

    do_reset(1'b0, 2'b00);
    check("reset_values", outs(), rst_vals);

    for (int i = 0; i < 16; i++) begin
      resetdone        = tbl[i].rd;
      status_vector[0] = tbl[i].lk;
      cfg_speed        = tbl[i].spd;
      step(tbl[i].n);
      check($sformatf("t1_row%0d", i), outs(), tbl[i].exp);
    end

    // Link pattern 1,1,1,0 never settles: WAIT_LINK times out after LINK_TIMEOUT cycles
    do_reset(1'b1, 2'b00);
    saw_up = 1'b0;
    snap   = '0;
    for (int c = 0; c <= 4112; c++) begin
      status_vector[0] = ((c % 4) != 3);
      step(1);
      saw_up = saw_up | link_up;
      if (c + 1 == 4112) snap = outs();
    end
    check("t2_no_link_up", {15'd0, saw_up}, 16'd0);
    check("t2_before_timeout", snap, pk(0, 0, 0, CFG_AN, 0, 0, 0, 0, 3'd0, 0));
    check("t2_after_timeout", outs(), pk(1, 1, 0, CFG_AN, 0, 0, 0, 0, 3'd1, 0));
    status_vector[0] = 1'b0;
    step(20);
    check("t2_wait_link_retry1", outs(), pk(0, 0, 0, CFG_AN, 0, 0, 0, 0, 3'd1, 0));
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    check("t2_restart_mid_attempt", outs(), pk(1, 1, 0, CFG_AN, 0, 0, 0, 0, 3'd0, 0));

    // resetdone stuck low: eight WAIT_DONE timeouts end in FAIL
    do_reset(1'b0, 2'b00);
    step(1040);
    check("t3_first_timeout", outs(), pk(1, 1, 0, CFG_AN, 0, 0, 0, 0, 3'd1, 0));
    step(7279);
    check("t3_last_wait_done", outs(), pk(0, 0, 0, CFG_AN, 0, 0, 0, 0, 3'd7, 0));
    step(1);
    check("t3_fail_entry", outs(), pk(1, 1, 0, CFG_AN, 0, 0, 0, 0, 3'd7, 1));
    step(100);
    check("t3_fail_held", outs(), pk(1, 1, 0, CFG_AN, 0, 0, 0, 0, 3'd7, 1));
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    check("t3_restart_from_fail", outs(), pk(1, 1, 0, CFG_AN, 0, 0, 0, 0, 3'd0, 0));

    // Reset and restart together in WAIT_LINK: reset wins
    do_reset(1'b1, 2'b10);
    step(20);
    check("t6_wait_link_10m", outs(), pk(0, 0, 0, CFG_AN, 1, 0, 0, 0, 3'd0, 0));
    rst     = 1'b1;
    restart = 1'b1;
    step(1);
    check("t6_reset_over_restart", outs(), rst_vals);
    rst     = 1'b0;
    restart = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
